// File: rtl/ahb3lite_irq_gen_if.sv
// ============================================================================
//  Module      : ahb3lite_irq_gen_if
//  Description : AHB3-Lite bus bundle for the IRQ generator slave.
//                The master modport is the bus side (fabric / testbench),
//                and the slave modport is the register block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ahb3lite_irq_gen_if;
  logic        HSEL;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADYOUT;

  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HRESP, HREADYOUT
  );

  modport master (
    output HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HRESP, HREADYOUT
  );
endinterface

`default_nettype wire

// File: rtl/ahb3lite_irq_gen.sv
// ============================================================================
//  Module      : ahb3lite_irq_gen
//  Description : AHB3-Lite slave that raises IRQ lines from software, either
//                as persistent levels (LEVEL) or as shared-timer pulses
//                (EDGE). 32 IRQs per register word, IRQ_CNT need not be a
//                multiple of 32. Unserviceable accesses get a two-cycle
//                AHB ERROR response.
//                Optional macro IRQ_GEN_SET_CLR_EN adds the LEVEL_SET
//                (0x300) and LEVEL_CLR (0x400) regions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb3lite_irq_gen #(
  parameter int IRQ_CNT   = 240,
  parameter int PULSE_LEN = 4
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  ahb3lite_irq_gen_if.slave     bus,
  output logic [IRQ_CNT-1:0]    IRQ
);

  localparam int NBANK = (IRQ_CNT + 31) / 32;
  localparam int NB32  = NBANK * 32;
  localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1;

  localparam logic [3:0] REG_LEVEL  = 4'h0;
  localparam logic [3:0] REG_EDGE   = 4'h1;
  localparam logic [3:0] REG_STATUS = 4'h2;
`ifdef IRQ_GEN_SET_CLR_EN
  localparam logic [3:0] REG_SET    = 4'h3;
  localparam logic [3:0] REG_CLR    = 4'h4;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t                   state_q, state_d;
  logic [NBANK-1:0][31:0]   level_q;
  logic [NBANK-1:0][31:0]   edge_q;
  logic [15:0]              cnt_q;
  logic                     wr_q;
  logic [3:0]               wr_reg_q;
  logic [BW-1:0]            wr_bank_q;
  logic [31:0]              hrdata_q;

  logic          w_valid, w_err, w_bank_ok, w_region_ok;
  logic [3:0]    w_region;
  logic [BW-1:0] w_bank;
  logic          w_wr_fire, w_lvl_wr, w_edge_load, w_fwd;
  logic [31:0]   w_wdata, w_lvl_old, w_lvl_new, w_rdata;
  logic [NB32-1:0] w_irq_flat;

  // Bits of bank b that map onto real IRQ lines; the rest read 0 and drop writes.
  function automatic logic [31:0] f_mask(input logic [BW-1:0] b);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = ((32 * int'(b)) + i) < IRQ_CNT;
    end
    return m;
  endfunction

  assign w_valid   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_region  = bus.HADDR[11:8];
  assign w_bank    = bus.HADDR[2 +: BW];
  assign w_bank_ok = ({26'd0, bus.HADDR[7:2]} < NBANK);

  // Which regions exist for this access direction.
  always_comb begin
    w_region_ok = 1'b0;
    case (w_region)
      REG_LEVEL, REG_EDGE: w_region_ok = 1'b1;
      REG_STATUS:          w_region_ok = ~bus.HWRITE;
`ifdef IRQ_GEN_SET_CLR_EN
      REG_SET, REG_CLR:    w_region_ok = 1'b1;
`endif
      default:             w_region_ok = 1'b0;
    endcase
  end

  assign w_err = w_valid & ((bus.HSIZE != 3'd2) | (bus.HADDR[1:0] != 2'b00) |
                            ~w_bank_ok | ~w_region_ok);

  // Data phase of an accepted write completes when HREADY is high.
  assign w_wr_fire = wr_q & bus.HREADY;
  assign w_wdata   = bus.HWDATA & f_mask(wr_bank_q);
  assign w_lvl_old = level_q[wr_bank_q];

  // New LEVEL word produced by the write currently in its data phase.
  always_comb begin
    w_lvl_new = w_lvl_old;
    w_lvl_wr  = 1'b0;
    if (w_wr_fire) begin
      case (wr_reg_q)
        REG_LEVEL: begin w_lvl_new = w_wdata;              w_lvl_wr = 1'b1; end
`ifdef IRQ_GEN_SET_CLR_EN
        REG_SET:   begin w_lvl_new = w_lvl_old | w_wdata;  w_lvl_wr = 1'b1; end
        REG_CLR:   begin w_lvl_new = w_lvl_old & ~w_wdata; w_lvl_wr = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  assign w_edge_load = w_wr_fire & (wr_reg_q == REG_EDGE) & (|w_wdata);
  assign w_fwd       = w_lvl_wr & (wr_bank_q == w_bank);

  // Read mux for the address phase; a same-word write in flight is forwarded.
  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_LEVEL:  w_rdata = w_fwd ? w_lvl_new : level_q[w_bank];
`ifdef IRQ_GEN_SET_CLR_EN
      REG_SET,
      REG_CLR:    w_rdata = w_fwd ? w_lvl_new : level_q[w_bank];
`endif
      REG_STATUS: w_rdata = level_q[w_bank] | edge_q[w_bank];
      default:    w_rdata = '0;
    endcase
  end

  // Response FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Response FSM next state and bus response outputs.
  always_comb begin
    state_d       = state_q;
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = w_err ? ST_ERR1 : ST_IDLE;
      ST_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
        state_d       = ST_ERR2;
      end
      ST_ERR2: begin
        bus.HRESP = 1'b1;
        state_d   = w_err ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register bank, pulse timer, data-phase capture and read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level_q   <= '0;
      edge_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      wr_reg_q  <= '0;
      wr_bank_q <= '0;
      hrdata_q  <= '0;
    end else begin
      if (w_lvl_wr) level_q[wr_bank_q] <= w_lvl_new;

      // A fresh EDGE write restarts the shared timer, extending every pulse.
      if (w_edge_load) begin
        edge_q[wr_bank_q] <= edge_q[wr_bank_q] | w_wdata;
        cnt_q             <= 16'(PULSE_LEN);
      end else if (cnt_q != 16'd0) begin
        cnt_q <= cnt_q - 16'd1;
        if (cnt_q == 16'd1) edge_q <= '0;
      end

      if (bus.HREADY) begin
        wr_q      <= w_valid & ~w_err & bus.HWRITE;
        wr_reg_q  <= w_region;
        wr_bank_q <= w_bank;
      end

      if (w_valid & ~w_err & ~bus.HWRITE) hrdata_q <= w_rdata;
    end
  end

  assign bus.HRDATA = hrdata_q;
  assign w_irq_flat = level_q | edge_q;
  assign IRQ        = w_irq_flat[IRQ_CNT-1:0];

  generate
    if (NB32 > IRQ_CNT) begin : g_pad
      // Padding bits above IRQ_CNT are held at zero by the write masks.
      logic w_unused_pad;
      assign w_unused_pad = &{1'b0, w_irq_flat[NB32-1:IRQ_CNT]};
    end
  endgenerate

  logic w_unused_bus;
  assign w_unused_bus = &{1'b0, bus.HBURST, bus.HPROT, bus.HADDR[31:12], bus.HTRANS[0]};

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_irq_gen.sv
// ============================================================================
//  Module      : tb_ahb3lite_irq_gen
//  Description : Self-checking bench for ahb3lite_irq_gen (IRQ_CNT=40,
//                PULSE_LEN=4) with a transaction-level reference model and
//                directed vectors. Honours IRQ_GEN_SET_CLR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb3lite_irq_gen;
  localparam int IRQ_CNT   = 40;
  localparam int PULSE_LEN = 4;
  localparam int NBANK     = 2;
`ifdef IRQ_GEN_SET_CLR_EN
  localparam bit SETCLR = 1'b1;
`else
  localparam bit SETCLR = 1'b0;
`endif
  localparam logic [63:0] VALID = 64'h0000_00FF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IRQ_CNT-1:0] irq;

  ahb3lite_irq_gen_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb3lite_irq_gen #(.IRQ_CNT(IRQ_CNT), .PULSE_LEN(PULSE_LEN)) dut (
    .CLK(clk), .RESET(rst), .bus(bus), .IRQ(irq)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_level = '0;
  logic [63:0] m_edge  = '0;
  logic [31:0] m_rdata = '0;
  int          m_off   = -1;   // cycle at which pending pulses end
  int          m_errph = 0;    // 0 none, 1 first error cycle, 2 second
  int          cyc     = 0;
  bit          m_init  = 0;
  bit          m_pw    = 0;
  int          m_pw_rg, m_pw_bk;

  always @(posedge clk) begin
    logic [63:0] irq_now;
    logic [31:0] d;
    int rg, bk, nxt;
    bit bad, reload, hrdy;
    if (rst) begin
      m_level = '0; m_edge = '0; m_rdata = '0; m_off = -1;
      m_errph = 0; m_pw = 0; m_init = 1; cyc = 0;
    end else begin
      cyc++;
      irq_now = m_level | m_edge;
      hrdy    = (m_errph != 1);
      reload  = 0;
      if (m_pw && hrdy) begin
        d = bus.HWDATA & VALID[m_pw_bk*32 +: 32];
        case (m_pw_rg)
          0: m_level[m_pw_bk*32 +: 32] = d;
          1: if (d != 0) begin
               m_edge[m_pw_bk*32 +: 32] = m_edge[m_pw_bk*32 +: 32] | d;
               m_off = cyc + PULSE_LEN; reload = 1;
             end
          3: m_level[m_pw_bk*32 +: 32] = m_level[m_pw_bk*32 +: 32] | d;
          4: m_level[m_pw_bk*32 +: 32] = m_level[m_pw_bk*32 +: 32] & ~d;
          default: ;
        endcase
        m_pw = 0;
      end
      if (!reload && cyc == m_off) m_edge = '0;
      nxt = (m_errph == 1) ? 2 : 0;
      if (hrdy && bus.HSEL && bus.HTRANS[1]) begin
        rg  = int'(bus.HADDR[11:8]);
        bk  = int'(bus.HADDR[7:2]);
        bad = (bus.HSIZE != 3'd2) || (bus.HADDR[1:0] != 2'b00) || (bk >= NBANK) ||
              !(rg == 0 || rg == 1 || (rg == 2 && !bus.HWRITE) ||
                (SETCLR && (rg == 3 || rg == 4)));
        if (bad) nxt = 1;
        else if (bus.HWRITE) begin
          m_pw = 1; m_pw_rg = rg; m_pw_bk = bk;
        end else begin
          case (rg)
            2:       m_rdata = irq_now[bk*32 +: 32];
            1:       m_rdata = '0;
            default: m_rdata = m_level[bk*32 +: 32];
          endcase
        end
      end
      m_errph = nxt;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init && !rst) begin
      chk("irq",       64'(irq),           64'(m_level[39:0] | m_edge[39:0]));
      chk("hreadyout", 64'(bus.HREADYOUT), 64'(m_errph != 1));
      chk("hresp",     64'(bus.HRESP),     64'(m_errph != 0));
      chk("hrdata",    64'(bus.HRDATA),    64'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic sel, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd);
    bus.HSEL   = sel;
    bus.HTRANS = sel ? 2'b10 : 2'b00;
    bus.HADDR  = a;
    bus.HWRITE = w;
    bus.HSIZE  = sz;
    bus.HWDATA = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] wd);
    beat(1'b0, 32'h0, 1'b0, 3'd2, wd);
  endtask

  task automatic rsp(input string name, input logic rdy, input logic resp);
    chk({name, "_rdy"},  64'(bus.HREADYOUT), 64'(rdy));
    chk({name, "_resp"}, 64'(bus.HRESP),     64'(resp));
  endtask

  initial begin
    bus.HBURST = 3'd0;
    bus.HPROT  = 4'd0;
    idle(32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_irq", 64'(irq), 64'h0);
    rsp("reset", 1'b1, 1'b0);
    chk("reset_hrdata", 64'(bus.HRDATA), 64'h0);

    // Reads of LEVEL0 and STATUS0 after reset.
    beat(1'b1, 32'h000, 1'b0, 3'd2, 32'h0);
    chk("rd_level0", 64'(bus.HRDATA), 64'h0);
    rsp("rd_level0", 1'b1, 1'b0);
    beat(1'b1, 32'h200, 1'b0, 3'd2, 32'h0);
    chk("rd_status0", 64'(bus.HRDATA), 64'h0);
    idle(32'h0);

    // Partial last bank: only 8 bits of LEVEL1 exist.
    beat(1'b1, 32'h004, 1'b1, 3'd2, 32'h0);
    idle(32'hFFFF_FFFF);
    chk("lvl1_irq", 64'(irq[39:32]), 64'hFF);
    chk("model_lvl1", m_level[63:32], 64'h0000_00FF);
    beat(1'b1, 32'h004, 1'b0, 3'd2, 32'h0);
    chk("rd_level1", 64'(bus.HRDATA), 64'h0000_00FF);

    // Back-to-back write then read of the same word.
    beat(1'b1, 32'h000, 1'b1, 3'd2, 32'h0);
    beat(1'b1, 32'h000, 1'b0, 3'd2, 32'hA5A5_A5A5);
    chk("fwd_hrdata", 64'(bus.HRDATA), 64'hA5A5_A5A5);
    rsp("fwd", 1'b1, 1'b0);
    chk("fwd_irq", 64'(irq[31:0]), 64'hA5A5_A5A5);
    beat(1'b1, 32'h000, 1'b1, 3'd2, 32'h0);
    idle(32'h0);

    // Single EDGE pulse: exactly PULSE_LEN cycles.
    beat(1'b1, 32'h100, 1'b1, 3'd2, 32'h0);
    idle(32'h5);
    chk("edge_p0", 64'(irq[3:0]), 64'h5);
    for (int k = 1; k < 4; k++) begin
      idle(32'h0);
      chk("edge_hold", 64'(irq[3:0]), 64'h5);
    end
    idle(32'h0);
    chk("edge_drop", 64'(irq[3:0]), 64'h0);

    // Second EDGE write two cycles in restarts the shared timer.
    beat(1'b1, 32'h100, 1'b1, 3'd2, 32'h0);
    idle(32'h5);
    beat(1'b1, 32'h100, 1'b1, 3'd2, 32'h0);
    chk("edge2_a", 64'(irq[3:0]), 64'h5);
    idle(32'h8);
    chk("edge2_b", 64'(irq[3:0]), 64'hD);
    for (int k = 1; k < 4; k++) begin
      idle(32'h0);
      chk("edge2_hold", 64'(irq[3:0]), 64'hD);
    end
    idle(32'h0);
    chk("edge2_drop", 64'(irq[3:0]), 64'h0);

    // Error responses: byte read, then write to STATUS issued in ERR2.
    beat(1'b1, 32'h000, 1'b1, 3'd2, 32'h0);
    beat(1'b1, 32'h000, 1'b0, 3'd0, 32'h0000_00F0);
    rsp("byte_err1", 1'b0, 1'b1);
    idle(32'h0);
    rsp("byte_err2", 1'b1, 1'b1);
    beat(1'b1, 32'h200, 1'b1, 3'd2, 32'h0);
    rsp("stat_err1", 1'b0, 1'b1);
    idle(32'h1234_5678);
    rsp("stat_err2", 1'b1, 1'b1);
    beat(1'b1, 32'h000, 1'b0, 3'd2, 32'h0);
    rsp("after_err", 1'b1, 1'b0);
    chk("after_err_data", 64'(bus.HRDATA), 64'h0000_00F0);

`ifdef IRQ_GEN_SET_CLR_EN
    beat(1'b1, 32'h300, 1'b1, 3'd2, 32'h0);
    beat(1'b1, 32'h400, 1'b1, 3'd2, 32'h0000_000F);
    beat(1'b1, 32'h000, 1'b0, 3'd2, 32'h0000_0030);
    chk("setclr_level", 64'(bus.HRDATA), 64'h0000_00CF);
    beat(1'b1, 32'h300, 1'b0, 3'd2, 32'h0);
    chk("setclr_rd_set", 64'(bus.HRDATA), 64'h0000_00CF);
    idle(32'h0);
`else
    beat(1'b1, 32'h300, 1'b1, 3'd2, 32'h0);
    rsp("set_unmapped", 1'b0, 1'b1);
    idle(32'h0000_000F);
    idle(32'h0);
    beat(1'b1, 32'h000, 1'b0, 3'd2, 32'h0);
    chk("set_unmapped_lvl", 64'(bus.HRDATA), 64'h0000_00F0);
`endif

    // Boundaries: out-of-range bank, masked-away EDGE data, EDGE read, misaligned.
    beat(1'b1, 32'h008, 1'b0, 3'd2, 32'h0);
    rsp("bank_oor", 1'b0, 1'b1);
    idle(32'h0);
    idle(32'h0);
    beat(1'b1, 32'h104, 1'b1, 3'd2, 32'h0);
    idle(32'hFFFF_FF00);
    beat(1'b1, 32'h100, 1'b0, 3'd2, 32'h0);
    chk("edge_rd_zero", 64'(bus.HRDATA), 64'h0);
    beat(1'b1, 32'h202, 1'b0, 3'd2, 32'h0);
    rsp("misalign", 1'b0, 1'b1);

    // Reset in the middle of an error response.
    rst = 1'b1;
    idle(32'h0);
    rsp("rst_in_err", 1'b1, 1'b0);
    chk("rst_irq", 64'(irq), 64'h0);
    rst = 1'b0;
    idle(32'h0);
    idle(32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb3lite_irq_gen.md
Name: ahb3lite_irq_gen

Overview:
Parametrised AHB3-Lite slave that lets software raise IRQs, either as persistent levels or as timed pulses, for any IRQ_CNT (not only multiples of 32). Registers are banked 32 IRQs per word. Accesses it cannot serve get a proper two-cycle AHB ERROR response. It sits on the system AHB fabric and drives the interrupt controller's IRQ inputs, typically for test or emulation.

Parameters:
IRQ_CNT, 240, number of IRQ outputs, 1..2048; NBANK = ceil(IRQ_CNT/32).
PULSE_LEN, 4, edge pulse duration in CLK cycles, 1..65535.

Ports:
CLK  input  1  clock.
RESET  input  1  reset, synchronous, active-high.
HSEL  input  1  slave select.
HWRITE  input  1  write=1.
HREADY  input  1  bus ready; address phase sampled only when high.
HADDR  input  32  address; only [11:0] decoded.
HTRANS  input  2  transfer type; NONSEQ/SEQ valid.
HSIZE  input  3  transfer size.
HBURST  input  3  unused.
HPROT  input  4  unused.
HWDATA  input  32  write data, data phase.
HRDATA  output  32  read data, registered.
HRESP  output  1  0=OKAY, 1=ERROR.
HREADYOUT  output  1  slave ready.
IRQ  output  IRQ_CNT  interrupt lines.

Behaviour:
- Reset values: LEVEL=0, edge_q=0, pulse counter=0, HRDATA=0, HRESP=0, HREADYOUT=1, IRQ=0. Reset during an error response returns the FSM to IDLE at once.
- Valid transfer: HSEL & HREADY & HTRANS[1]. Capture address, write flag and size into the data-phase registers.
- Address map, bank b = 0..NBANK-1, offset 4*b:
  - 0x000 LEVEL (RW).
  - 0x100 EDGE (WO; reads return 0).
  - 0x200 STATUS (RO; current IRQ word).
  - 0x300 LEVEL_SET and 0x400 LEVEL_CLR, only under the optional feature.
- Error conditions: HSIZE!=2, offset beyond NBANK in a region, unmapped region, write to STATUS, or HADDR[1:0]!=0. These give an ERROR response; registers are unchanged.
- Bit rules: bits at or above IRQ_CNT in the last bank read 0 and ignore writes.
- Write timing: HWDATA is applied at the end of the data phase. The new LEVEL is visible on IRQ the next cycle. IRQ = LEVEL | edge_q, taken directly from flops.
- EDGE write:
  - edge_q[bank] |= data, and the pulse counter loads PULSE_LEN.
  - The counter decrements each cycle. On the cycle it reaches 0, all of edge_q is cleared.
  - A new EDGE write while counting restarts the shared counter, so pending pulses are extended.
  - EDGE write with data 0: no counter reload.
- Reads: zero-wait. HRDATA is registered from the address phase, valid in the data phase.
- Read-after-write hazard: a read address phase coinciding with a write data phase to the same word must return the written value. Forward HWDATA into HRDATA (masked per the bit rules).
- Response FSM:
  - IDLE: HREADYOUT=1, HRESP=0. An error-condition transfer goes to ERR1.
  - ERR1: HREADYOUT=0, HRESP=1, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, then IDLE. A new valid transfer sampled in ERR2 is decoded normally.
  - Transfers are not sampled in ERR1 (HREADY is low).
- IDLE/BUSY HTRANS, or HSEL=0: OKAY, no state change.

Optional Feature:
IRQ_GEN_SET_CLR_EN.
- Defined: LEVEL_SET (0x300+4b, WO) sets LEVEL |= data. LEVEL_CLR (0x400+4b, WO) sets LEVEL &= ~data. Reads of either return the LEVEL word. Write-to-read forwarding applies the set/clear result.
- Undefined: both regions decode as unmapped and return ERROR.

Test Plan:
1. Reset, then read LEVEL0 and STATUS0 -> 0x00000000, OKAY, zero wait; IRQ=0.
2. IRQ_CNT=40: write LEVEL1=0xFFFFFFFF -> IRQ[39:32]=0xFF; read LEVEL1 -> 0x000000FF.
3. PULSE_LEN=4: write EDGE0=0x5 -> IRQ[0] and IRQ[2] high for exactly 4 cycles. A second EDGE0=0x8 written 2 cycles in -> bits 0,2,3 all drop 4 cycles after the second write.
4. Back-to-back write LEVEL0=0xA5A5A5A5 then read LEVEL0 -> HRDATA=0xA5A5A5A5 in the read's data phase, no wait state.
5. Byte read (HSIZE=0) of LEVEL0, and a write to STATUS0 -> each gets HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; LEVEL unchanged. A following valid read completes OKAY.
6. With IRQ_GEN_SET_CLR_EN: LEVEL0=0xF0, SET0=0x0F, CLR0=0x30 -> LEVEL0 reads 0xCF. Without the macro, a write to 0x300 -> ERROR.
